// File: rtl/key_pkg.sv
// Shared types, default timing and counter width helper for the key conditioning block.
package key_pkg;

  typedef enum logic [2:0] {
    RELEASED   = 3'd0,
    PRESS_WAIT = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    REL_WAIT   = 3'd4
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 1000;
  localparam int DEF_REPEAT_CYCLES   = 250;

  // Width of a counter that must reach max_val; never narrower than 1 bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_sync.sv
// Polarity normalisation and 2-flop synchroniser; key_s = 1 means pressed.
module key_debounce_sync #(
  parameter int ACTIVE_HIGH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_s
);

  logic key_n;
  logic meta_d, meta_q;
  logic sync_d, sync_q;

  assign key_n = key_raw ^ (ACTIVE_HIGH == 0);

  always_comb begin
    meta_d = key_n;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign key_s = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces a raw key into a clean level plus press/release/hold/repeat pulses.
//   state      | meaning
//   RELEASED   | key idle, level 0
//   PRESS_WAIT | counting consecutive pressed samples
//   PRESSED    | level 1, counting towards long-press
//   HELD       | long-press reached, generating auto-repeat
//   REL_WAIT   | counting consecutive released samples, hold/repeat frozen
module key_debounce
  import key_pkg::*;
#(
  parameter int ACTIVE_HIGH     = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_hold,
  output logic key_repeat
);

  localparam int DB_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int REP_W  = cnt_w(REPEAT_CYCLES);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_CYCLES);
  localparam bit DB_ONE  = (DEBOUNCE_CYCLES == 1);
  localparam bit REP_EN  = (REPEAT_CYCLES != 0);

  logic key_s;

  key_state_e state_d, state_q;
  key_state_e origin_d, origin_q;
  logic [DB_W-1:0]   db_cnt_d, db_cnt_q, db_inc;
  logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q, hold_inc;
  logic [REP_W-1:0]  rep_cnt_d, rep_cnt_q, rep_inc;
  logic level_d, level_q;
  logic press_d, press_q;
  logic rel_d, rel_q;
  logic hold_d, hold_q;
  logic rpt_d, rpt_q;

  key_debounce_sync #(.ACTIVE_HIGH(ACTIVE_HIGH)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .key_raw (key_raw),
    .key_s   (key_s)
  );

  // Saturating increments; db_inc is the sample count including the current one.
  assign db_inc   = (db_cnt_q == DB_MAX)     ? db_cnt_q   : db_cnt_q + DB_W'(1);
  assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
  assign rep_inc  = (rep_cnt_q == REP_MAX)   ? rep_cnt_q  : rep_cnt_q + REP_W'(1);

  always_comb begin
    state_d    = state_q;
    origin_d   = origin_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    hold_d     = 1'b0;
    rpt_d      = 1'b0;
    case (state_q)
      RELEASED: begin
        level_d  = 1'b0;
        db_cnt_d = '0;
        if (key_s) begin
          if (DB_ONE) begin
            state_d    = PRESSED;
            level_d    = 1'b1;
            press_d    = 1'b1;
            hold_cnt_d = '0;
          end else begin
            state_d  = PRESS_WAIT;
            db_cnt_d = DB_W'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d  = RELEASED;
          db_cnt_d = '0;
        end else if (db_inc == DB_MAX) begin
          state_d    = PRESSED;
          level_d    = 1'b1;
          press_d    = 1'b1;
          hold_cnt_d = '0;
          db_cnt_d   = '0;
        end else begin
          db_cnt_d = db_inc;
        end
      end
      PRESSED, HELD: begin
        if (!key_s) begin
          origin_d = state_q;
          if (DB_ONE) begin
            state_d = RELEASED;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            state_d  = REL_WAIT;
            db_cnt_d = DB_W'(1);
          end
        end else if (state_q == PRESSED) begin
          hold_cnt_d = hold_inc;
          if (hold_inc == HOLD_MAX) begin
            hold_d    = 1'b1;
            state_d   = HELD;
            rep_cnt_d = '0;
          end
        end else if (REP_EN) begin
          rep_cnt_d = rep_inc;
          if (rep_inc == REP_MAX) begin
            rpt_d     = 1'b1;
            rep_cnt_d = '0;
          end
        end
      end
      REL_WAIT: begin
        if (key_s) begin
          state_d  = origin_q;
          db_cnt_d = '0;
        end else if (db_inc == DB_MAX) begin
          state_d  = RELEASED;
          level_d  = 1'b0;
          rel_d    = 1'b1;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_inc;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RELEASED;
      origin_q   <= PRESSED;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      hold_q     <= 1'b0;
      rpt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      origin_q   <= origin_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      hold_q     <= hold_d;
      rpt_q      <= rpt_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign key_hold    = hold_q;
  assign key_repeat  = rpt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench: DUT a (active-high, repeat 8) and DUT b (active-low, no repeat); expected
// pulses are queued by edge number at stimulus time and compared every cycle.
module tb_key_debounce;

  localparam logic [3:0] EV_PRESS = 4'b1000;
  localparam logic [3:0] EV_REL   = 4'b0100;
  localparam logic [3:0] EV_HOLD  = 4'b0010;
  localparam logic [3:0] EV_RPT   = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] ev;
  } sb_t;

  logic clk;
  logic rst;
  logic key_raw_a, key_raw_b;
  logic lvl_a, press_a, rel_a, hold_a, rpt_a;
  logic lvl_b, press_b, rel_b, hold_b, rpt_b;

  int  cyc;
  bit  rst_seen;
  int  n_chk;
  int  n_err;
  sb_t sb_a[$];
  sb_t sb_b[$];
  bit  exp_lvl_a, exp_lvl_b;

  key_debounce #(
    .ACTIVE_HIGH(1), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut_a (
    .clk(clk), .rst(rst), .key_raw(key_raw_a),
    .key_level(lvl_a), .key_press(press_a), .key_release(rel_a),
    .key_hold(hold_a), .key_repeat(rpt_a)
  );

  key_debounce #(
    .ACTIVE_HIGH(0), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .key_raw(key_raw_b),
    .key_level(lvl_b), .key_press(press_b), .key_release(rel_b),
    .key_hold(hold_b), .key_repeat(rpt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc      = 0;
    rst_seen = 1'b1;
  end

  always @(posedge clk) begin
    cyc      = cyc + 1;
    rst_seen = rst;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int d, input int c, input logic [3:0] ev);
    sb_t e;
    e.cyc = c;
    e.ev  = ev;
    if (d == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
  endtask

  // Pops this edge's expected pulses (if any) and compares pulses and level.
  always @(negedge clk) begin
    logic [3:0] exp_a, exp_b;
    if (cyc > 0) begin
      exp_a = 4'b0000;
      exp_b = 4'b0000;
      if (sb_a.size() > 0 && sb_a[0].cyc == cyc) exp_a = sb_a.pop_front().ev;
      if (sb_b.size() > 0 && sb_b[0].cyc == cyc) exp_b = sb_b.pop_front().ev;
      if (rst_seen)            exp_lvl_a = 1'b0;
      else if (exp_a[3])       exp_lvl_a = 1'b1;
      else if (exp_a[2])       exp_lvl_a = 1'b0;
      if (rst_seen)            exp_lvl_b = 1'b0;
      else if (exp_b[3])       exp_lvl_b = 1'b1;
      else if (exp_b[2])       exp_lvl_b = 1'b0;
      chk("a_pulses", int'({press_a, rel_a, hold_a, rpt_a}), int'(exp_a));
      chk("a_level",  int'(lvl_a), int'(exp_lvl_a));
      chk("b_pulses", int'({press_b, rel_b, hold_b, rpt_b}), int'(exp_b));
      chk("b_level",  int'(lvl_b), int'(exp_lvl_b));
    end
  end

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    bit pat [7];
    n_chk     = 0;
    n_err     = 0;
    exp_lvl_a = 1'b0;
    exp_lvl_b = 1'b0;
    rst       = 1'b1;
    key_raw_a = 1'b0;
    key_raw_b = 1'b1;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset for edges 1..3, press before edge 10, held 40 edges.
    to_cyc(3);  rst = 1'b0;
    to_cyc(9);  key_raw_a = 1'b1;
    push(0, 15, EV_PRESS); push(0, 35, EV_HOLD);
    push(0, 43, EV_RPT);   push(0, 51, EV_RPT);
    to_cyc(54); key_raw_a = 1'b0;
    push(0, 60, EV_REL);

    // Bounce shorter than the debounce window: no events.
    to_cyc(69);
    for (int i = 0; i < 7; i++) begin
      key_raw_a = pat[i];
      @(negedge clk);
    end

    // Bounce while PRESSED freezes hold_cnt; bounce while releasing from HELD.
    to_cyc(89);  key_raw_a = 1'b1;
    push(0, 95, EV_PRESS);  push(0, 118, EV_HOLD);
    push(0, 126, EV_RPT);   push(0, 134, EV_RPT);
    to_cyc(99);  key_raw_a = 1'b0;
    to_cyc(101); key_raw_a = 1'b1;
    to_cyc(137); key_raw_a = 1'b0;
    to_cyc(139); key_raw_a = 1'b1;
    to_cyc(141); key_raw_a = 1'b0;
    push(0, 147, EV_REL);

    // Reset pulse while HELD with key still down: no release, fresh press.
    to_cyc(159); key_raw_a = 1'b1;
    push(0, 165, EV_PRESS); push(0, 185, EV_HOLD); push(0, 193, EV_RPT);
    to_cyc(195); rst = 1'b1;
    to_cyc(196); rst = 1'b0;
    push(0, 202, EV_PRESS); push(0, 222, EV_HOLD); push(0, 230, EV_RPT);
    to_cyc(232); key_raw_a = 1'b0;
    push(0, 238, EV_REL);

    // Active-low key with repeat disabled.
    to_cyc(249); key_raw_b = 1'b0;
    push(1, 255, EV_PRESS); push(1, 275, EV_HOLD);
    to_cyc(294); key_raw_b = 1'b1;
    push(1, 300, EV_REL);

    to_cyc(320);
    chk("a_sb_empty", sb_a.size(), 0);
    chk("b_sb_empty", sb_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
